// File: rtl/enc16to4_rr.sv
// ---------------------------------------------------------------------------
// enc16to4_rr
//
// Purpose:
//   16-to-4 priority encoder with a single registered output stage and a
//   valid/ready handshake on both sides. A 16-bit (possibly multi-hot)
//   request vector is accepted, one set bit is granted, and the grant is
//   presented as a 4-bit index, a 16-bit one-hot and a "more than one bit
//   was set" flag one cycle later.
//
// Grant policy (compile-time macro ENC16TO4_RR_EN):
//   defined   : rotating priority. Search starts at an internal pointer
//               (inclusive) and wraps 15 -> 0; after each grant the pointer
//               moves to grant+1. The pointer resets to RESET_PTR.
//   undefined : fixed priority, lowest set index wins. No pointer register;
//               RESET_PTR has no effect.
//
// Handshake (both ports): a beat transfers on a cycle where valid and ready
//   are both 1. in_rdy = !out_vld | out_rdy, so a held output that is being
//   consumed frees the register for a new beat in the same cycle. An
//   accepted all-zero request is dropped and produces no output. While
//   out_vld & !out_rdy the output fields are held stable.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset (wins over any handshake)
//   in         in  16  request vector
//   in_vld     in   1  in is valid
//   in_rdy     out  1  block accepts in this cycle
//   out        out  4  granted index
//   out_onehot out 16  one-hot of granted index
//   out_multi  out  1  accepted request had two or more bits set
//   out_vld    out  1  output fields valid
//   out_rdy    in   1  consumer takes the output this cycle
// ---------------------------------------------------------------------------
module enc16to4_rr #(
  parameter logic [3:0] RESET_PTR = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic [3:0]  out,
  output logic [15:0] out_onehot,
  output logic        out_multi,
  output logic        out_vld,
  input  logic        out_rdy
);

  logic        out_vld_q, out_vld_d;
  logic [3:0]  out_q, out_d;
  logic [15:0] onehot_q, onehot_d;
  logic        multi_q, multi_d;

  logic        accept;
  logic        take;
  logic [3:0]  grant_idx;

  assign in_rdy = !out_vld_q | out_rdy;
  assign accept = in_vld & in_rdy;
  // A zero request is accepted (consumed) but never produces an output.
  assign take   = accept & (|in);

`ifdef ENC16TO4_RR_EN
  logic [3:0] ptr_q, ptr_d;

  // Rotating search: visit ptr, ptr+1, ... (4-bit wrap) and keep the first hit.
  always_comb begin
    logic       found;
    logic [3:0] cand;
    grant_idx = 4'd0;
    found     = 1'b0;
    cand      = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!found && in[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = grant_idx + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= RESET_PTR;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan downward so the lowest set index is written last.
  always_comb begin
    grant_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (in[i]) grant_idx = 4'(i);
    end
  end

  // RESET_PTR only matters for the rotating policy.
  logic unused_reset_ptr;
  assign unused_reset_ptr = ^RESET_PTR;
`endif

  // Output register next state: load on a nonzero accept, otherwise retire
  // the held beat when the consumer takes it, otherwise hold.
  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    onehot_d  = onehot_q;
    multi_d   = multi_q;
    if (take) begin
      out_vld_d = 1'b1;
      out_d     = grant_idx;
      onehot_d  = 16'd1 << grant_idx;
      // Clearing the lowest set bit leaves something iff two or more were set.
      multi_d   = |(in & (in - 16'd1));
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= 4'd0;
      onehot_q  <= 16'h0000;
      multi_q   <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      onehot_q  <= onehot_d;
      multi_q   <= multi_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out        = out_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;

endmodule
